// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router egress arbiter
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam logic [1:0] GRANT_NONE = 2'b11;
    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_PRESENT
    } state_e;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/router_rr_picker.sv
// rtl/router_rr_picker.sv - picks the next FIFO to serve from the request vector
// Fixed priority 0>1>2 when ROUTER_EGRESS_FIXED_PRIO_EN is defined, round-robin otherwise.
module router_rr_picker
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] request,
    input  logic [1:0]           last_grant,
    output logic [1:0]           winner,
    output logic                 valid
);

`ifdef ROUTER_EGRESS_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        winner = GRANT_NONE;
        valid  = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (request[i]) begin
                winner = 2'(i);
                valid  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic [1:0] idx;
        winner = GRANT_NONE;
        valid  = 1'b0;
        idx    = next_port(last_grant);
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!valid && request[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
            idx = next_port(idx);
        end
    end
`endif

endmodule

// File: rtl/router_egress_arb.sv
// rtl/router_egress_arb.sv - drains whole packets from three FIFOs onto one egress port
// Arbitration is fixed priority when ROUTER_EGRESS_FIXED_PRIO_EN is defined.
module router_egress_arb
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sop,
    output logic       out_eop,
    output logic [1:0] grant,
    output logic       busy,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic               first_q, first_d;

    logic [NUM_PORTS-1:0] request;
    logic [1:0]           pick_winner;
    logic                 pick_valid;
    logic [3:0]           grant_oh;
    logic [7:0]           data_sel;
    logic                 empty_sel;
    logic [2:0]           rd_vec;
    logic [2:0]           sr_vec;

    assign request  = ~{fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign grant_oh = 4'b0001 << grant_q;

    router_rr_picker u_picker (
        .request    (request),
        .last_grant (last_grant_q),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_comb begin
        data_sel  = 8'h00;
        empty_sel = 1'b1;
        case (grant_q)
            2'd0: begin data_sel = data_out_0; empty_sel = fifo_empty_0; end
            2'd1: begin data_sel = data_out_1; empty_sel = fifo_empty_1; end
            2'd2: begin data_sel = data_out_2; empty_sel = fifo_empty_2; end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        stall_d      = stall_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        first_d      = first_q;
        rd_vec       = 3'b000;
        sr_vec       = 3'b000;
        case (state_q)
            ST_IDLE: begin
                grant_d = GRANT_NONE;
                if (pick_valid) begin
                    grant_d      = pick_winner;
                    last_grant_d = pick_winner;
                    first_d      = 1'b1;
                    state_d      = ST_READ;
                end
            end
            ST_READ: begin
                if (!empty_sel) begin
                    rd_vec  = grant_oh[2:0];
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                out_data_d  = data_sel;
                out_valid_d = 1'b1;
                sop_d       = first_q;
                // Counter holds payload+parity still to send; parity is the byte seen at count 1.
                eop_d       = !first_q && (cnt_q == CNT_W'(1));
                if (first_q) begin
                    cnt_d = CNT_W'(data_sel[HDR_LEN_MSB:HDR_LEN_LSB]) + CNT_W'(1);
                end
                first_d = 1'b0;
                stall_d = '0;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    sop_d       = 1'b0;
                    eop_d       = 1'b0;
                    stall_d     = '0;
                    if (!sop_q) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (cnt_d == '0) begin
                        grant_d = GRANT_NONE;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                    sr_vec      = grant_oh[2:0];
                    out_valid_d = 1'b0;
                    sop_d       = 1'b0;
                    eop_d       = 1'b0;
                    stall_d     = '0;
                    cnt_d       = '0;
                    grant_d     = GRANT_NONE;
                    state_d     = ST_IDLE;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_NONE;
            last_grant_q <= 2'd2;
            cnt_q        <= '0;
            stall_q      <= '0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            first_q      <= first_d;
        end
    end

    assign read_enb_0   = rd_vec[0];
    assign read_enb_1   = rd_vec[1];
    assign read_enb_2   = rd_vec[2];
    assign soft_reset_0 = sr_vec[0];
    assign soft_reset_1 = sr_vec[1];
    assign soft_reset_2 = sr_vec[2];
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_sop      = sop_q;
    assign out_eop      = eop_q;
    assign grant        = grant_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_router_egress_arb.sv
// tb/tb_router_egress_arb.sv - directed self-checking bench for router_egress_arb
module tb_router_egress_arb;

    logic       clock = 1'b0;
    logic       reset;
    logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
    logic [7:0] data_out_0 = 8'h00, data_out_1 = 8'h00, data_out_2 = 8'h00;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_sop, out_eop, busy;
    logic [1:0] grant;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    router_egress_arb #(.TIMEOUT(30)) dut (
        .clock        (clock),
        .reset        (reset),
        .fifo_empty_0 (fifo_empty_0),
        .fifo_empty_1 (fifo_empty_1),
        .fifo_empty_2 (fifo_empty_2),
        .data_out_0   (data_out_0),
        .data_out_1   (data_out_1),
        .data_out_2   (data_out_2),
        .read_enb_0   (read_enb_0),
        .read_enb_1   (read_enb_1),
        .read_enb_2   (read_enb_2),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .grant        (grant),
        .busy         (busy),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2)
    );

    // FIFO models: pop on read_enb, data valid the next cycle, flush on soft_reset.
    logic [7:0] q0[$], q1[$], q2[$];

    always @(posedge clock) begin
        if (soft_reset_0) q0.delete();
        else if (read_enb_0 && q0.size() > 0) data_out_0 <= q0.pop_front();
        if (soft_reset_1) q1.delete();
        else if (read_enb_1 && q1.size() > 0) data_out_1 <= q1.pop_front();
        if (soft_reset_2) q2.delete();
        else if (read_enb_2 && q2.size() > 0) data_out_2 <= q2.pop_front();
        fifo_empty_0 <= (q0.size() == 0);
        fifo_empty_1 <= (q1.size() == 0);
        fifo_empty_2 <= (q2.size() == 0);
    end

    typedef struct {
        logic [1:0] g;
        logic       sop;
        logic       eop;
        logic [7:0] d;
        int         cyc;
    } beat_t;

    beat_t beats[$];
    int    cyc = 0;
    int    sr_count = 0;
    int    viol = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && out_valid && out_ready)
            beats.push_back('{grant, out_sop, out_eop, out_data, cyc});
        sr_count <= sr_count + int'(soft_reset_0) + int'(soft_reset_1) + int'(soft_reset_2);
        if ((2'(read_enb_0) + 2'(read_enb_1) + 2'(read_enb_2)) > 2'd1 ||
            (read_enb_0 && grant != 2'd0) || (read_enb_1 && grant != 2'd1) ||
            (read_enb_2 && grant != 2'd2) || (soft_reset_0 && grant != 2'd0) ||
            (soft_reset_1 && grant != 2'd1) || (soft_reset_2 && grant != 2'd2))
            viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input string tag, input int limit);
        int k = 0;
        while (!busy && k < limit) begin @(negedge clock); k++; end
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        while (busy && k < limit) begin @(negedge clock); k++; end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int k = 0;
        while (!out_valid && k < limit) begin @(negedge clock); k++; end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_beats(input string tag, input int n, input int limit);
        int k = 0;
        while (beats.size() < n && k < limit) begin @(negedge clock); k++; end
        check({tag, "_beats"}, 32'(beats.size()), 32'(n));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_t1[5];
        logic [7:0] exp_t5[4];
        int         seen;
        int         sr_base;

        exp_t1 = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5E};
        exp_t5 = '{8'h08, 8'h91, 8'h92, 8'h9F};
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_grant", 32'(grant), 32'd3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_strobes", 32'({out_sop, out_eop, read_enb_0, read_enb_1, read_enb_2,
                                  soft_reset_0, soft_reset_1, soft_reset_2}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // L=3 packet from FIFO0: latency, framing and one byte per 3 cycles
        beats.delete();
        q0.push_back(8'h0C); q0.push_back(8'hA1); q0.push_back(8'hA2);
        q0.push_back(8'hA3); q0.push_back(8'h5E);
        wait_busy("t1", 20);
        check("t1_grant", 32'(grant), 32'd0);
        check("t1_lat_read", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("t1_lat_capture", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("t1_lat_present", 32'(out_valid), 32'd1);
        check("t1_first_sop", 32'(out_sop), 32'd1);
        check("t1_first_data", 32'(out_data), 32'h0C);
        wait_beats("t1", 5, 100);
        wait_idle("t1", 20);
        for (int i = 0; i < 5 && i < beats.size(); i++) begin
            check($sformatf("t1_data%0d", i), 32'(beats[i].d), 32'(exp_t1[i]));
            check($sformatf("t1_sop%0d", i), 32'(beats[i].sop), 32'(i == 0));
            check($sformatf("t1_eop%0d", i), 32'(beats[i].eop), 32'(i == 4));
            check($sformatf("t1_g%0d", i), 32'(beats[i].g), 32'd0);
            if (i > 0) check($sformatf("t1_gap%0d", i), 32'(beats[i].cyc - beats[i-1].cyc), 32'd3);
        end
        check("t1_grant_end", 32'(grant), 32'd3);

        // All FIFOs loaded right after reset: round-robin 0,1,2,0
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        beats.delete();
        q0.push_back(8'h02); q0.push_back(8'hB0); q0.push_back(8'h02); q0.push_back(8'hB1);
        q1.push_back(8'h02); q1.push_back(8'hC0);
        q2.push_back(8'h02); q2.push_back(8'hD0);
        wait_beats("t2", 8, 300);
        if (beats.size() == 8) begin
            check("t2_g0", 32'(beats[0].g), 32'd0);
            check("t2_g1", 32'(beats[2].g), 32'd1);
            check("t2_g2", 32'(beats[4].g), 32'd2);
            check("t2_g3", 32'(beats[6].g), 32'd0);
            check("t2_par0", 32'({beats[1].eop, beats[1].d}), 32'h1B0);
            check("t2_par1", 32'({beats[3].eop, beats[3].d}), 32'h1C0);
            check("t2_par2", 32'({beats[5].eop, beats[5].d}), 32'h1D0);
            check("t2_par3", 32'({beats[7].eop, beats[7].d}), 32'h1B1);
        end
        wait_idle("t2", 20);

        // 10-cycle backpressure mid-payload: data held, no abort
        beats.delete();
        sr_base = sr_count;
        out_ready = 1'b0;
        q0.push_back(8'h0C); q0.push_back(8'hE1); q0.push_back(8'hE2);
        q0.push_back(8'hE3); q0.push_back(8'hEF);
        wait_valid("t3_hdr", 50);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        wait_valid("t3_p1", 50);
        check("t3_p1_data", 32'(out_data), 32'hE1);
        check("t3_p1_sop", 32'(out_sop), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("t3_hold%0d", k), 32'({out_valid, out_sop, out_eop, out_data}), 32'h4E1);
        end
        out_ready = 1'b1;
        wait_beats("t3", 5, 100);
        wait_idle("t3", 20);
        check("t3_no_abort", 32'(sr_count - sr_base), 32'd0);
        if (beats.size() == 5) check("t3_last", 32'({beats[4].eop, beats[4].d}), 32'h1EF);

        // FIFO1 stalled for TIMEOUT cycles: single soft_reset_1 pulse and abort
        beats.delete();
        sr_base = sr_count;
        out_ready = 1'b0;
        q1.push_back(8'h08); q1.push_back(8'hF1); q1.push_back(8'hF2); q1.push_back(8'hF3);
        wait_valid("t4", 50);
        check("t4_grant", 32'(grant), 32'd1);
        seen = 0;
        for (int k = 1; k < 30; k++) begin
            seen += int'(soft_reset_1);
            @(negedge clock);
        end
        check("t4_no_early_abort", 32'(seen), 32'd0);
        check("t4_pulse", 32'(soft_reset_1), 32'd1);
        check("t4_valid_before", 32'(out_valid), 32'd1);
        @(negedge clock);
        check("t4_pulse_end", 32'(soft_reset_1), 32'd0);
        check("t4_valid_drop", 32'(out_valid), 32'd0);
        check("t4_grant_none", 32'(grant), 32'd3);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_pulse_count", 32'(sr_count - sr_base), 32'd1);
        check("t4_no_beats", 32'(beats.size()), 32'd0);
        out_ready = 1'b1;

        // FIFO2 runs dry mid-packet: stall in READ, then resume without loss
        beats.delete();
        q2.push_back(8'h08); q2.push_back(8'h91);
        wait_beats("t5_part", 2, 100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("t5_stall%0d", k), 32'({busy, read_enb_2, out_valid}), 32'b100);
        end
        q2.push_back(8'h92); q2.push_back(8'h9F);
        wait_beats("t5", 4, 100);
        wait_idle("t5", 20);
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            check($sformatf("t5_data%0d", i), 32'({beats[i].g, beats[i].sop, beats[i].eop, beats[i].d}),
                  32'({2'd2, 1'(i == 0), 1'(i == 3), exp_t5[i]}));
        end

        // L=0 packet: header plus parity only
        beats.delete();
        q0.push_back(8'h02); q0.push_back(8'h77);
        wait_beats("t6", 2, 100);
        wait_idle("t6", 20);
        check("t6_count", 32'(beats.size()), 32'd2);
        if (beats.size() >= 2) begin
            check("t6_hdr", 32'({beats[0].sop, beats[0].eop, beats[0].d}), 32'h202);
            check("t6_par", 32'({beats[1].sop, beats[1].eop, beats[1].d}), 32'h177);
        end

        // Reset mid-packet: asynchronous return to reset values, no abort pulse
        beats.delete();
        sr_base = sr_count;
        q0.push_back(8'h0C); q0.push_back(8'h11); q0.push_back(8'h12);
        q0.push_back(8'h13); q0.push_back(8'h14);
        wait_beats("t7", 2, 100);
        wait_valid("t7_mid", 20);
        #2;
        reset = 1'b1;
        #1;
        check("t7_valid", 32'(out_valid), 32'd0);
        check("t7_grant", 32'(grant), 32'd3);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_data", 32'(out_data), 32'h00);
        check("t7_strobes", 32'({out_sop, out_eop, read_enb_0, read_enb_1, read_enb_2,
                                 soft_reset_0, soft_reset_1, soft_reset_2}), 32'd0);
        q0.delete();
        @(negedge clock);
        check("t7_no_pulse", 32'(sr_count - sr_base), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        check("strobe_rules", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
